// File: rtl/sync_pulse_receiver.sv
// Receive end of the PMT sync-pulse link: synchronises the raw pulse, measures its width and
// period, qualifies it against the expected timing and flywheels a switch-trigger window while locked.
module sync_pulse_receiver #(
    parameter int CNT_W       = 12,
    parameter int EXP_WIDTH   = 480,
    parameter int EXP_PERIOD  = 2400,
    parameter int TOL         = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int MISS_LIMIT  = 2,
    parameter int TRIG_OFFSET = 2395,
    parameter int TRIG_LEN    = 5
) (
    input  logic             sysclk_i,
    input  logic             btn_i,
    input  logic             pulse_in_i,
    output logic             locked_o,
    output logic             pulse_seen_o,
    output logic             pulse_valid_o,
    output logic             miss_o,
    output logic [CNT_W-1:0] meas_period_o,
    output logic [CNT_W-1:0] meas_width_o,
    output logic             switch_trig_o,
    output logic [1:0]       state_o
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_OUT   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] PER_LO  = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] PER_HI  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] WID_LO  = CNT_W'(EXP_WIDTH - TOL);
    localparam logic [CNT_W-1:0] WID_HI  = CNT_W'(EXP_WIDTH + TOL);
    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(EXP_PERIOD - 1);
    localparam logic [CNT_W-1:0] TRIG_LO = CNT_W'(TRIG_OFFSET);
    localparam logic [CNT_W:0]   TRIG_HI = (CNT_W+1)'(TRIG_OFFSET + TRIG_LEN);

    // SEARCH: waiting for any rise | ACQUIRE: counting good periods | LOCKED: flywheel running
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] wid_cnt_q, wid_cnt_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic [CNT_W-1:0] meas_width_q, meas_width_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
    logic             pulse_seen_q, pulse_valid_q, miss_q, switch_trig_q;
    logic             pulse_valid_d, switch_trig_d;

    logic             rise, fall, timeout, valid_rise;
    logic [CNT_W-1:0] per_inc, wid_inc;

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign per_inc = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_ONE;
    assign wid_inc = (wid_cnt_q == CNT_MAX) ? CNT_MAX : wid_cnt_q + CNT_ONE;
    // A rise on the timeout cycle wins, so a late-but-present pulse is never also a miss.
    assign timeout = (per_cnt_q == T_OUT) & ~rise;
    // Width under test is the one captured at the fall preceding this rise.
    assign valid_rise = rise
                      & (per_inc >= PER_LO) & (per_inc <= PER_HI)
                      & (meas_width_q >= WID_LO) & (meas_width_q <= WID_HI);

    always_comb begin
        per_cnt_d     = per_inc;
        wid_cnt_d     = wid_cnt_q;
        meas_period_d = meas_period_q;
        meas_width_d  = meas_width_q;
        if (rise) begin
            per_cnt_d     = '0;
            meas_period_d = per_inc;
        end else if (timeout) begin
            per_cnt_d = TOL_V;
        end
        if (rise) begin
            wid_cnt_d = CNT_ONE;
        end else if (s2_q) begin
            wid_cnt_d = wid_inc;
        end
        if (fall) begin
            meas_width_d = wid_cnt_q;
        end else if (s2_q && wid_cnt_q == CNT_MAX) begin
            meas_width_d = CNT_MAX;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                if (rise) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (rise) begin
                    if (valid_rise) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    if (valid_rise) begin
                        miss_cnt_d = '0;
                    end else begin
                        state_d    = ST_ACQUIRE;
                        good_cnt_d = '0;
                    end
                end else if (timeout) begin
                    miss_cnt_d = miss_cnt_q + MW'(1);
                    if (miss_cnt_q == MW'(MISS_LIMIT - 1)) begin
                        state_d = ST_SEARCH;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        phase_d = '0;
        if (state_q == ST_LOCKED && state_d == ST_LOCKED && !valid_rise) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + CNT_ONE;
        end
        // Computed from next state so the window drops on the same edge as lock.
        switch_trig_d = (state_d == ST_LOCKED) && (phase_d >= TRIG_LO)
                      && ({1'b0, phase_d} < TRIG_HI);
        pulse_valid_d = valid_rise && (state_q != ST_SEARCH);
    end

    always_ff @(posedge sysclk_i or negedge btn_i) begin
        if (!btn_i) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            state_q       <= ST_SEARCH;
            per_cnt_q     <= '0;
            wid_cnt_q     <= '0;
            meas_period_q <= '0;
            meas_width_q  <= '0;
            phase_q       <= '0;
            good_cnt_q    <= '0;
            miss_cnt_q    <= '0;
            pulse_seen_q  <= 1'b0;
            pulse_valid_q <= 1'b0;
            miss_q        <= 1'b0;
            switch_trig_q <= 1'b0;
        end else begin
            s1_q          <= pulse_in_i;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            wid_cnt_q     <= wid_cnt_d;
            meas_period_q <= meas_period_d;
            meas_width_q  <= meas_width_d;
            phase_q       <= phase_d;
            good_cnt_q    <= good_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            pulse_seen_q  <= rise;
            pulse_valid_q <= pulse_valid_d;
            miss_q        <= timeout;
            switch_trig_q <= switch_trig_d;
        end
    end

    assign locked_o      = (state_q == ST_LOCKED);
    assign pulse_seen_o  = pulse_seen_q;
    assign pulse_valid_o = pulse_valid_q;
    assign miss_o        = miss_q;
    assign meas_period_o = meas_period_q;
    assign meas_width_o  = meas_width_q;
    assign switch_trig_o = switch_trig_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_sync_pulse_receiver.sv
// Directed bench for sync_pulse_receiver: locking, flywheel, invalid period, width window,
// stuck-high input and asynchronous reset, with hand-computed expectations.
module tb_sync_pulse_receiver;

    logic        clk = 1'b0;
    logic        btn = 1'b0;
    logic        pulse_in = 1'b0;
    logic        locked, pulse_seen, pulse_valid, miss, switch_trig;
    logic [11:0] meas_period, meas_width;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    int   seen_cnt = 0, valid_cnt = 0, miss_cnt = 0;
    int   trig_runs = 0, trig_len_cur = 0, trig_len_last = 0;
    logic trig_prev = 1'b0, trig_before_seen = 1'b0;

    sync_pulse_receiver dut (
        .sysclk_i      (clk),
        .btn_i         (btn),
        .pulse_in_i    (pulse_in),
        .locked_o      (locked),
        .pulse_seen_o  (pulse_seen),
        .pulse_valid_o (pulse_valid),
        .miss_o        (miss),
        .meas_period_o (meas_period),
        .meas_width_o  (meas_width),
        .switch_trig_o (switch_trig),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pulse_seen) begin
            seen_cnt++;
            trig_before_seen = trig_prev;
        end
        if (pulse_valid) valid_cnt++;
        if (miss) miss_cnt++;
        if (switch_trig) begin
            trig_len_cur++;
        end else if (trig_prev) begin
            trig_runs++;
            trig_len_last = trig_len_cur;
            trig_len_cur  = 0;
        end
        trig_prev = switch_trig;
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive_period(input int w, input int p);
        for (int i = 0; i < p; i++) begin
            pulse_in = (i < w);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_tests++;
        if ({locked, pulse_seen, pulse_valid, miss, switch_trig} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=00000", {locked, pulse_seen, pulse_valid, miss, switch_trig});
        end
        n_tests++;
        if (meas_period !== 12'd0 || meas_width !== 12'd0) begin
            n_fail++; $display("FAIL reset_meas got=%0d/%0d exp=0/0", meas_period, meas_width);
        end
    endtask

    task automatic test_lock;
        int v0, s0;
        logic [1:0] exp_st;
        v0 = valid_cnt;
        s0 = seen_cnt;
        for (int i = 1; i <= 5; i++) begin
            drive_period(480, 2400);
            exp_st = (i < 5) ? 2'd1 : 2'd2;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL lock_state rise=%0d got=%0d exp=%0d", i, state, exp_st); end
            n_tests++;
            if (valid_cnt - v0 !== i - 1) begin n_fail++; $display("FAIL lock_valid rise=%0d got=%0d exp=%0d", i, valid_cnt - v0, i - 1); end
        end
        n_tests++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked got=%b exp=1", locked); end
        n_tests++;
        if (meas_period !== 12'd2400) begin n_fail++; $display("FAIL lock_period got=%0d exp=2400", meas_period); end
        n_tests++;
        if (meas_width !== 12'd480) begin n_fail++; $display("FAIL lock_width got=%0d exp=480", meas_width); end
        n_tests++;
        if (seen_cnt - s0 !== 5) begin n_fail++; $display("FAIL lock_seen got=%0d exp=5", seen_cnt - s0); end
    endtask

    task automatic test_flywheel;
        int m0, t0, v0;
        m0 = miss_cnt; t0 = trig_runs;
        drive_period(0, 2400);
        n_tests++;
        if (miss_cnt - m0 !== 1) begin n_fail++; $display("FAIL fly_miss got=%0d exp=1", miss_cnt - m0); end
        n_tests++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL fly_locked got=%b exp=1", locked); end
        n_tests++;
        if (trig_runs - t0 !== 1 || trig_len_last !== 5) begin
            n_fail++; $display("FAIL fly_trig_drop runs=%0d len=%0d exp=1/5", trig_runs - t0, trig_len_last);
        end
        m0 = miss_cnt; t0 = trig_runs; v0 = valid_cnt;
        drive_period(480, 2400);
        n_tests++;
        if (meas_period !== 12'd2399) begin n_fail++; $display("FAIL fly_period got=%0d exp=2399", meas_period); end
        n_tests++;
        if (valid_cnt - v0 !== 1 || miss_cnt - m0 !== 0) begin
            n_fail++; $display("FAIL fly_resume valid=%0d miss=%0d exp=1/0", valid_cnt - v0, miss_cnt - m0);
        end
        n_tests++;
        if (trig_runs - t0 !== 1 || trig_len_last !== 5 || trig_before_seen !== 1'b1) begin
            n_fail++; $display("FAIL fly_trig_phase runs=%0d len=%0d before_seen=%b exp=1/5/1", trig_runs - t0, trig_len_last, trig_before_seen);
        end
    endtask

    task automatic test_bad_period;
        int m0, t0, v0;
        logic [1:0] exp_st;
        m0 = miss_cnt;
        drive_period(480, 2420);
        t0 = trig_runs; v0 = valid_cnt;
        drive_period(480, 2400);
        n_tests++;
        if (state !== 2'd1 || locked !== 1'b0) begin n_fail++; $display("FAIL bad_state got=%0d/%b exp=1/0", state, locked); end
        n_tests++;
        if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL bad_valid got=%0d exp=0", valid_cnt - v0); end
        n_tests++;
        if (miss_cnt - m0 !== 1) begin n_fail++; $display("FAIL bad_miss got=%0d exp=1", miss_cnt - m0); end
        n_tests++;
        if (trig_runs - t0 !== 0 || switch_trig !== 1'b0 || trig_before_seen !== 1'b0) begin
            n_fail++; $display("FAIL bad_trig runs=%0d trig=%b before_seen=%b exp=0/0/0", trig_runs - t0, switch_trig, trig_before_seen);
        end
        for (int i = 1; i <= 4; i++) begin
            drive_period(480, 2400);
            exp_st = (i < 4) ? 2'd1 : 2'd2;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL relock_state rise=%0d got=%0d exp=%0d", i, state, exp_st); end
        end
    endtask

    task automatic test_async_reset;
        logic [1:0] exp_st;
        drive_period(100, 100);
        n_tests++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL arst_pre_locked got=%b exp=1", locked); end
        #2;
        btn = 1'b0;
        #1;
        n_tests++;
        if (state !== 2'd0 || {locked, pulse_seen, pulse_valid, miss, switch_trig} !== 5'b0) begin
            n_fail++; $display("FAIL arst_outputs state=%0d strobes=%b exp=0/00000", state, {locked, pulse_seen, pulse_valid, miss, switch_trig});
        end
        n_tests++;
        if (meas_period !== 12'd0 || meas_width !== 12'd0) begin
            n_fail++; $display("FAIL arst_meas got=%0d/%0d exp=0/0", meas_period, meas_width);
        end
        pulse_in = 1'b0;
        cyc(5);
        btn = 1'b1;
        cyc(2);
        for (int i = 1; i <= 5; i++) begin
            drive_period(480, 2400);
            exp_st = (i < 5) ? 2'd1 : 2'd2;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL arst_relock rise=%0d got=%0d exp=%0d", i, state, exp_st); end
        end
    endtask

    task automatic test_drop_two;
        int m0, t0;
        m0 = miss_cnt; t0 = trig_runs;
        drive_period(0, 2400);
        n_tests++;
        if (locked !== 1'b1 || miss_cnt - m0 !== 1 || trig_runs - t0 !== 1) begin
            n_fail++; $display("FAIL drop1 locked=%b miss=%0d runs=%0d exp=1/1/1", locked, miss_cnt - m0, trig_runs - t0);
        end
        m0 = miss_cnt;
        drive_period(0, 2400);
        n_tests++;
        if (state !== 2'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL drop2_state got=%0d/%b exp=0/0", state, locked); end
        n_tests++;
        if (miss_cnt - m0 !== 1) begin n_fail++; $display("FAIL drop2_miss got=%0d exp=1", miss_cnt - m0); end
    endtask

    task automatic test_width_sweep;
        int wtab [5] = '{471, 472, 488, 489, 480};
        int vtab [5] = '{0, 0, 1, 1, 0};
        int v0;
        logic [1:0] exp_st;
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            drive_period(wtab[i], 2400);
            n_tests++;
            if (valid_cnt - v0 !== vtab[i]) begin
                n_fail++; $display("FAIL sweep_valid prev_w=%0d got=%0d exp=%0d", (i > 0) ? wtab[i-1] : 0, valid_cnt - v0, vtab[i]);
            end
            n_tests++;
            if (meas_width !== 12'(wtab[i])) begin n_fail++; $display("FAIL sweep_width got=%0d exp=%0d", meas_width, wtab[i]); end
        end
        for (int i = 1; i <= 4; i++) begin
            drive_period(480, 2400);
            exp_st = (i < 4) ? 2'd1 : 2'd2;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL sweep_relock rise=%0d got=%0d exp=%0d", i, state, exp_st); end
        end
    endtask

    task automatic test_stuck_high;
        int m0;
        m0 = miss_cnt;
        drive_period(2420, 2420);
        n_tests++;
        if (locked !== 1'b1 || miss_cnt - m0 !== 1 || meas_width !== 12'd480) begin
            n_fail++; $display("FAIL stuck_first locked=%b miss=%0d width=%0d exp=1/1/480", locked, miss_cnt - m0, meas_width);
        end
        drive_period(2410, 2410);
        n_tests++;
        if (meas_width !== 12'd4095) begin n_fail++; $display("FAIL stuck_width got=%0d exp=4095", meas_width); end
        n_tests++;
        if (miss_cnt - m0 !== 2) begin n_fail++; $display("FAIL stuck_miss got=%0d exp=2", miss_cnt - m0); end
        n_tests++;
        if (state !== 2'd0 || locked !== 1'b0 || switch_trig !== 1'b0) begin
            n_fail++; $display("FAIL stuck_state got=%0d/%b/%b exp=0/0/0", state, locked, switch_trig);
        end
        pulse_in = 1'b0;
        cyc(5);
    endtask

    initial begin
        btn = 1'b0;
        pulse_in = 1'b0;
        cyc(3);
        test_reset;
        btn = 1'b1;
        cyc(2);
        test_lock;
        test_flywheel;
        test_bad_period;
        test_async_reset;
        test_drop_two;
        test_width_sweep;
        test_stuck_high;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
